// File: rtl/clock_set_ctrl_if.sv
// Key flag inputs and time-setting outputs of the clock set controller.
interface clock_set_ctrl_if;
  logic       mode_p;
  logic       mode_r;
  logic       up_p;
  logic       up_r;
  logic       down_p;
  logic       down_r;
  logic [1:0] set_mode;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       clr_sec;
  logic       blink_en;

  // Key side: drives the debounced press/release flags, observes the controls.
  modport master (
    output mode_p, mode_r, up_p, up_r, down_p, down_r,
    input  set_mode, inc_pulse, dec_pulse, clr_sec, blink_en
  );

  // Controller side.
  modport slave (
    input  mode_p, mode_r, up_p, up_r, down_p, down_r,
    output set_mode, inc_pulse, dec_pulse, clr_sec, blink_en
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: MODE key sequences RUN/HOUR/MIN/SEC, UP/DOWN keys
// share one adjust path and produce inc/dec strobes with long-press repeat.
module clock_set_ctrl #(
  parameter int unsigned LONG_CNT = 50000000,
  parameter int unsigned REP_CNT  = 10000000,
  parameter int unsigned CW       = $clog2(LONG_CNT + 1)
) (
  input  logic            sys_clk,
  input  logic            rst,
  clock_set_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_HOUR = 2'b01;
  localparam logic [1:0] ST_MIN  = 2'b10;
  localparam logic [1:0] ST_SEC  = 2'b11;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_UP   = 2'b01;
  localparam logic [1:0] OWN_DOWN = 2'b10;

  localparam logic [CW-1:0] LONG_V     = CW'(LONG_CNT);
  localparam logic [CW-1:0] LONG_M1    = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] REP_RELOAD = CW'(LONG_CNT - REP_CNT);

  // State and output registers
  logic [1:0]    r_set_mode;
  logic          r_mode_held;
  logic [CW-1:0] r_mcnt;
  logic          r_clr_sec;
  logic [1:0]    r_own;
  logic [CW-1:0] r_acnt;
  logic          r_inc;
  logic          r_dec;
  logic          r_blink;

  // Next-state values
  logic [1:0]    w_step_mode;
  logic [1:0]    w_mode_nxt;
  logic          w_mode_held_nxt;
  logic [CW-1:0] w_mcnt_nxt;
  logic          w_clr_nxt;
  logic          w_mode_chg;
  logic [1:0]    w_own_nxt;
  logic [CW-1:0] w_acnt_nxt;
  logic          w_inc_nxt;
  logic          w_dec_nxt;
  logic          w_own_release;
  logic          w_rep_hit;
  logic [CW-1:0] w_acnt_step;

  // Short-press successor of the current set mode.
  always_comb begin
    w_step_mode = ST_RUN;
    case (r_set_mode)
      ST_RUN:  w_step_mode = ST_HOUR;
      ST_HOUR: w_step_mode = ST_MIN;
      ST_MIN:  w_step_mode = ST_SEC;
      ST_SEC:  w_step_mode = ST_RUN;
      default: w_step_mode = ST_RUN;
    endcase
  end

  // MODE key tracking; mcnt is the hold length in cycles, press cycle included.
  always_comb begin
    w_mode_held_nxt = r_mode_held;
    w_mcnt_nxt      = r_mcnt;
    w_mode_nxt      = r_set_mode;
    w_clr_nxt       = 1'b0;
    if (!r_mode_held) begin
      if (bus.mode_p) begin
        w_mode_held_nxt = 1'b1;
        w_mcnt_nxt      = CW'(1);
      end
    end else if (bus.mode_r) begin
      // A release after the long threshold was reached does nothing.
      w_mode_held_nxt = 1'b0;
      if (r_mcnt < LONG_V) begin
        w_mode_nxt = w_step_mode;
      end
    end else if (r_mcnt == LONG_M1) begin
      w_mcnt_nxt = LONG_V;
      if (r_set_mode == ST_RUN) begin
        w_clr_nxt = 1'b1;
      end else begin
        w_mode_nxt = ST_RUN;
      end
    end else if (r_mcnt < LONG_M1) begin
      w_mcnt_nxt = r_mcnt + CW'(1);
    end
  end

  assign w_mode_chg    = (w_mode_nxt != r_set_mode);
  assign w_own_release = ((r_own == OWN_UP)   && bus.up_r) ||
                         ((r_own == OWN_DOWN) && bus.down_r);
  assign w_rep_hit     = (r_acnt == LONG_M1);
  assign w_acnt_step   = w_rep_hit ? REP_RELOAD : (r_acnt + CW'(1));

  // Adjust-path ownership and inc/dec strobe generation.
  always_comb begin
    w_own_nxt  = r_own;
    w_acnt_nxt = r_acnt;
    w_inc_nxt  = 1'b0;
    w_dec_nxt  = 1'b0;
    if (w_mode_chg || (r_set_mode == ST_RUN)) begin
      // A mode change always wins over adjust activity in the same cycle.
      w_own_nxt  = OWN_NONE;
      w_acnt_nxt = '0;
    end else begin
      case (r_own)
        OWN_NONE: begin
          // UP wins a simultaneous press; the DOWN press is simply dropped.
          if (bus.up_p) begin
            w_own_nxt  = OWN_UP;
            w_acnt_nxt = '0;
            w_inc_nxt  = 1'b1;
          end else if (bus.down_p) begin
            w_own_nxt  = OWN_DOWN;
            w_acnt_nxt = '0;
            w_dec_nxt  = 1'b1;
          end
        end
        OWN_UP, OWN_DOWN: begin
          if (w_own_release) begin
            // Release on a repeat boundary suppresses that strobe.
            w_own_nxt  = OWN_NONE;
            w_acnt_nxt = '0;
          end else begin
            w_acnt_nxt = w_acnt_step;
            w_inc_nxt  = w_rep_hit && (r_own == OWN_UP);
            w_dec_nxt  = w_rep_hit && (r_own == OWN_DOWN);
          end
        end
        default: begin
          w_own_nxt  = OWN_NONE;
          w_acnt_nxt = '0;
        end
      endcase
    end
  end

  // State register for mode tracking, adjust path and registered outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_set_mode  <= ST_RUN;
      r_mode_held <= 1'b0;
      r_mcnt      <= '0;
      r_clr_sec   <= 1'b0;
      r_own       <= OWN_NONE;
      r_acnt      <= '0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_set_mode  <= w_mode_nxt;
      r_mode_held <= w_mode_held_nxt;
      r_mcnt      <= w_mcnt_nxt;
      r_clr_sec   <= w_clr_nxt;
      r_own       <= w_own_nxt;
      r_acnt      <= w_acnt_nxt;
      r_inc       <= w_inc_nxt;
      r_dec       <= w_dec_nxt;
      r_blink     <= (w_mode_nxt != ST_RUN);
    end
  end

  assign bus.set_mode  = r_set_mode;
  assign bus.inc_pulse = r_inc;
  assign bus.dec_pulse = r_dec;
  assign bus.clr_sec   = r_clr_sec;
  assign bus.blink_en  = r_blink;

endmodule
